// File: rtl/reg_file_pkg.sv
// Shared widths for the architectural register file. Widths follow the
// REG_NUM_WIDTH / ROB_SIZE_WIDTH macros, defaulting to 5 bits each.
`ifndef REG_NUM_WIDTH
`define REG_NUM_WIDTH 5
`endif

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif

package reg_file_pkg;

  localparam int REG_NUM_W = `REG_NUM_WIDTH;
  localparam int ROB_ID_W  = `ROB_SIZE_WIDTH;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << REG_NUM_W;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational source-operand read: x0 forcing, same-cycle commit bypass,
// otherwise the stored value/busy/tag of the selected register.
module rf_read_port
  import reg_file_pkg::*;
(
  input  logic [REG_NUM_W-1:0] rs,
  input  logic [DATA_W-1:0]    reg_value,
  input  logic                 reg_busy,
  input  logic [ROB_ID_W-1:0]  reg_tag,
  input  logic                 rob_valid,
  input  logic [REG_NUM_W-1:0] rob_rd,
  input  logic [DATA_W-1:0]    rob_value,
  input  logic [ROB_ID_W-1:0]  rob_rob_id,
  output logic [DATA_W-1:0]    value_out,
  output logic                 busy_out,
  output logic [ROB_ID_W-1:0]  dep_out
);

  always_comb begin
    value_out = reg_value;
    busy_out  = reg_busy;
    dep_out   = reg_tag;
    if (rs == '0) begin
      value_out = '0;
      busy_out  = 1'b0;
    end else if (rob_valid && (rob_rd == rs) && reg_busy && (reg_tag == rob_rob_id)) begin
      // The committing entry is exactly the one this source waits on.
      value_out = rob_value;
      busy_out  = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags (commit, issue, flush).
// Optional macro RF_COMMIT_CNT_EN adds a 32-bit count of committing cycles.
module reg_file
  import reg_file_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 dec_valid,
  input  logic [REG_NUM_W-1:0] dec_rd,
  input  logic [ROB_ID_W-1:0]  dec_rob_id,
  input  logic [REG_NUM_W-1:0] dec_rs1,
  input  logic [REG_NUM_W-1:0] dec_rs2,
  input  logic                 rob_valid,
  input  logic [REG_NUM_W-1:0] rob_rd,
  input  logic [DATA_W-1:0]    rob_value,
  input  logic [ROB_ID_W-1:0]  rob_rob_id,
  output logic [DATA_W-1:0]    rs1_value_out,
  output logic                 rs1_busy_out,
  output logic [ROB_ID_W-1:0]  rs1_dependency_out,
  output logic [DATA_W-1:0]    rs2_value_out,
  output logic                 rs2_busy_out,
  output logic [ROB_ID_W-1:0]  rs2_dependency_out
`ifdef RF_COMMIT_CNT_EN
  ,
  output logic [31:0]          commit_cnt_out
`endif
);

  logic [DATA_W-1:0]   value_q [NUM_REGS];
  logic [DATA_W-1:0]   value_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ROB_ID_W-1:0] tag_q [NUM_REGS];
  logic [ROB_ID_W-1:0] tag_d [NUM_REGS];
  logic                commit_en;

  assign commit_en = rdy_in && rob_valid && (rob_rd != '0);

  // Commit first, then issue (which wins on busy), then flush drops every busy bit.
  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    if (commit_en) begin
      value_d[rob_rd] = rob_value;
      if (tag_q[rob_rd] == rob_rob_id) busy_d[rob_rd] = 1'b0;
    end
    if (rdy_in) begin
      if (flush_in) begin
        busy_d = '0;
      end else if (dec_valid && (dec_rd != '0)) begin
        busy_d[dec_rd] = 1'b1;
        tag_d[dec_rd]  = dec_rob_id;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

`ifdef RF_COMMIT_CNT_EN
  logic [31:0] commit_cnt_q, commit_cnt_d;

  always_comb begin
    commit_cnt_d = commit_cnt_q;
    if (commit_en) commit_cnt_d = commit_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) commit_cnt_q <= '0;
    else        commit_cnt_q <= commit_cnt_d;
  end

  assign commit_cnt_out = commit_cnt_q;
`endif

  rf_read_port u_rs1 (
    .rs         (dec_rs1),
    .reg_value  (value_q[dec_rs1]),
    .reg_busy   (busy_q[dec_rs1]),
    .reg_tag    (tag_q[dec_rs1]),
    .rob_valid  (rob_valid),
    .rob_rd     (rob_rd),
    .rob_value  (rob_value),
    .rob_rob_id (rob_rob_id),
    .value_out  (rs1_value_out),
    .busy_out   (rs1_busy_out),
    .dep_out    (rs1_dependency_out)
  );

  rf_read_port u_rs2 (
    .rs         (dec_rs2),
    .reg_value  (value_q[dec_rs2]),
    .reg_busy   (busy_q[dec_rs2]),
    .reg_tag    (tag_q[dec_rs2]),
    .rob_valid  (rob_valid),
    .rob_rd     (rob_rd),
    .rob_value  (rob_value),
    .rob_rob_id (rob_rob_id),
    .value_out  (rs2_value_out),
    .busy_out   (rs2_busy_out),
    .dep_out    (rs2_dependency_out)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// against an array-based reference model of the register file.
module tb_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        dec_valid;
  logic [4:0]  dec_rd, dec_rob_id, dec_rs1, dec_rs2;
  logic        rob_valid;
  logic [4:0]  rob_rd, rob_rob_id;
  logic [31:0] rob_value;
  logic [31:0] rs1_value_out, rs2_value_out;
  logic        rs1_busy_out, rs2_busy_out;
  logic [4:0]  rs1_dependency_out, rs2_dependency_out;
`ifdef RF_COMMIT_CNT_EN
  logic [31:0] commit_cnt_out;
`endif

  always #5 clk_in = ~clk_in;

  reg_file dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .flush_in           (flush_in),
    .dec_valid          (dec_valid),
    .dec_rd             (dec_rd),
    .dec_rob_id         (dec_rob_id),
    .dec_rs1            (dec_rs1),
    .dec_rs2            (dec_rs2),
    .rob_valid          (rob_valid),
    .rob_rd             (rob_rd),
    .rob_value          (rob_value),
    .rob_rob_id         (rob_rob_id),
    .rs1_value_out      (rs1_value_out),
    .rs1_busy_out       (rs1_busy_out),
    .rs1_dependency_out (rs1_dependency_out),
    .rs2_value_out      (rs2_value_out),
    .rs2_busy_out       (rs2_busy_out),
    .rs2_dependency_out (rs2_dependency_out)
`ifdef RF_COMMIT_CNT_EN
    ,
    .commit_cnt_out     (commit_cnt_out)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what each architectural register holds, whether it is
  // waiting on the ROB, and which ROB entry it waits on.
  logic [31:0] m_val  [32];
  bit          m_busy [32];
  logic [4:0]  m_tag  [32];
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic rst = 1'b0, input logic rdy = 1'b1, input logic flush = 1'b0,
                       input logic dv = 1'b0, input logic [4:0] drd = 5'd0, input logic [4:0] did = 5'd0,
                       input logic rv = 1'b0, input logic [4:0] rrd = 5'd0,
                       input logic [31:0] rval = 32'd0, input logic [4:0] rid = 5'd0,
                       input logic [4:0] s1 = 5'd0, input logic [4:0] s2 = 5'd0);
    rst_in = rst; rdy_in = rdy; flush_in = flush;
    dec_valid = dv; dec_rd = drd; dec_rob_id = did;
    rob_valid = rv; rob_rd = rrd; rob_value = rval; rob_rob_id = rid;
    dec_rs1 = s1; dec_rs2 = s2;
  endtask

  task automatic check_src(input string nm, input logic [4:0] rs, input logic [31:0] v,
                           input logic b, input logic [4:0] d);
    logic [31:0] ev;
    bit          eb;
    if (rs == 5'd0) begin
      ev = 32'd0; eb = 1'b0;
    end else if (rob_valid && rob_rd == rs && m_busy[rs] && m_tag[rs] == rob_rob_id) begin
      ev = rob_value; eb = 1'b0;
    end else begin
      ev = m_val[rs]; eb = m_busy[rs];
    end
    chk({nm, "_value"}, v, ev);
    chk({nm, "_busy"}, {31'd0, b}, {31'd0, eb});
    if (eb) chk({nm, "_dep"}, {27'd0, d}, {27'd0, m_tag[rs]});
  endtask

  task automatic tick(input bit do_chk = 1'b1);
    if (do_chk) begin
      check_src("rs1", dec_rs1, rs1_value_out, rs1_busy_out, rs1_dependency_out);
      check_src("rs2", dec_rs2, rs2_value_out, rs2_busy_out, rs2_dependency_out);
`ifdef RF_COMMIT_CNT_EN
      chk("commit_cnt", commit_cnt_out, m_cnt);
`endif
    end
    @(posedge clk_in);
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 32'd0; m_busy[i] = 1'b0; m_tag[i] = 5'd0;
      end
      m_cnt = 32'd0;
    end else if (rdy_in) begin
      if (rob_valid && rob_rd != 5'd0) begin
        m_cnt = m_cnt + 32'd1;
        m_val[rob_rd] = rob_value;
        if (m_tag[rob_rd] == rob_rob_id) m_busy[rob_rd] = 1'b0;
      end
      if (flush_in) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (dec_valid && dec_rd != 5'd0) begin
        m_busy[dec_rd] = 1'b1;
        m_tag[dec_rd]  = dec_rob_id;
      end
    end
    @(negedge clk_in);
  endtask

  initial begin
    drive(.rst(1'b1));
    @(negedge clk_in);
    tick(1'b0);

    // Reset state and x0 behaviour
    drive(.s1(5'd5), .s2(5'd0)); #1;
    chk("rst_rs1_value", rs1_value_out, 32'd0);
    chk("rst_rs1_busy", {31'd0, rs1_busy_out}, 32'd0);
    chk("rst_rs1_dep", {27'd0, rs1_dependency_out}, 32'd0);
    chk("rst_rs2_busy", {31'd0, rs2_busy_out}, 32'd0);
    tick();
    drive(.dv(1'b1), .drd(5'd0), .did(5'd3)); #1; tick();
    drive(.s1(5'd0)); #1;
    chk("x0_busy", {31'd0, rs1_busy_out}, 32'd0);
    chk("x0_value", rs1_value_out, 32'd0);
    tick();

    // Issue, wait, bypass on commit, then stored value
    drive(.dv(1'b1), .drd(5'd7), .did(5'd4)); #1; tick();
    drive(.s1(5'd7)); #1;
    chk("x7_busy", {31'd0, rs1_busy_out}, 32'd1);
    chk("x7_dep", {27'd0, rs1_dependency_out}, 32'd4);
    tick();
    drive(.rv(1'b1), .rrd(5'd7), .rval(32'hDEADBEEF), .rid(5'd4), .s1(5'd7)); #1;
    chk("x7_bypass_value", rs1_value_out, 32'hDEADBEEF);
    chk("x7_bypass_busy", {31'd0, rs1_busy_out}, 32'd0);
    tick();
    drive(.s2(5'd7)); #1;
    chk("x7_stored_value", rs2_value_out, 32'hDEADBEEF);
    chk("x7_stored_busy", {31'd0, rs2_busy_out}, 32'd0);
    tick();

    // Stale commit: older writer's value lands but register stays busy
    drive(.dv(1'b1), .drd(5'd9), .did(5'd2)); #1; tick();
    drive(.dv(1'b1), .drd(5'd9), .did(5'd6)); #1; tick();
    drive(.rv(1'b1), .rrd(5'd9), .rval(32'h11), .rid(5'd2), .s1(5'd9)); #1;
    chk("x9_stale_busy", {31'd0, rs1_busy_out}, 32'd1);
    chk("x9_stale_dep", {27'd0, rs1_dependency_out}, 32'd6);
    tick();
    drive(.s1(5'd9)); #1;
    chk("x9_after_stale_busy", {31'd0, rs1_busy_out}, 32'd1);
    chk("x9_after_stale_value", rs1_value_out, 32'h11);
    tick();
    drive(.rv(1'b1), .rrd(5'd9), .rval(32'h22), .rid(5'd6)); #1; tick();
    drive(.s1(5'd9)); #1;
    chk("x9_final_busy", {31'd0, rs1_busy_out}, 32'd0);
    chk("x9_final_value", rs1_value_out, 32'h22);
    tick();

    // Same-cycle commit and issue on one register: issue keeps it busy
    drive(.dv(1'b1), .drd(5'd10), .did(5'd12), .rv(1'b1), .rrd(5'd10), .rval(32'h55), .rid(5'd8)); #1; tick();
    drive(.s2(5'd10)); #1;
    chk("x10_busy", {31'd0, rs2_busy_out}, 32'd1);
    chk("x10_dep", {27'd0, rs2_dependency_out}, 32'd12);
    chk("x10_value", rs2_value_out, 32'h55);
    tick();

    // Flush with link write and a discarded issue
    drive(.dv(1'b1), .drd(5'd3), .did(5'd1)); #1; tick();
    drive(.dv(1'b1), .drd(5'd4), .did(5'd2)); #1; tick();
    drive(.flush(1'b1), .dv(1'b1), .drd(5'd5), .did(5'd9), .rv(1'b1), .rrd(5'd1), .rval(32'h1004), .rid(5'd0)); #1; tick();
    drive(.s1(5'd3), .s2(5'd4)); #1;
    chk("flush_x3_busy", {31'd0, rs1_busy_out}, 32'd0);
    chk("flush_x4_busy", {31'd0, rs2_busy_out}, 32'd0);
    tick();
    drive(.s1(5'd1), .s2(5'd5)); #1;
    chk("flush_x1_value", rs1_value_out, 32'h1004);
    chk("flush_x5_busy", {31'd0, rs2_busy_out}, 32'd0);
    tick();

    // rdy_in low holds everything
    drive(.rdy(1'b0), .dv(1'b1), .drd(5'd11), .did(5'd7), .rv(1'b1), .rrd(5'd9), .rval(32'h99), .rid(5'd6)); #1; tick();
    drive(.s1(5'd11), .s2(5'd9)); #1;
    chk("hold_x11_busy", {31'd0, rs1_busy_out}, 32'd0);
    chk("hold_x9_value", rs2_value_out, 32'h22);
    tick();

    // Randomized traffic with a narrow register range to force collisions
    for (int n = 0; n < 3000; n++) begin
      drive(.rst($urandom_range(0, 199) == 0),
            .rdy($urandom_range(0, 9) != 0),
            .flush($urandom_range(0, 19) == 0),
            .dv($urandom_range(0, 1) == 1),
            .drd(5'($urandom_range(0, 7))),
            .did(5'($urandom)),
            .rv($urandom_range(0, 1) == 1),
            .rrd(5'($urandom_range(0, 7))),
            .rval($urandom),
            .rid(5'($urandom_range(0, 3))),
            .s1(5'($urandom_range(0, 7))),
            .s2(($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7))));
      #1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
